mat_mul_seq: RTL and testbench
==============================

# mat_mul_seq

Sequential 5×5 signed 8-bit matrix multiplier computing C = A × B one result element per clock. It sits directly upstream of the 25-byte result register bank. It delivers the finished 200-bit packed matrix together with a single-cycle write strobe, which loads the bank for addressed readback by the HPS. Operands are latched at start, so the host may change its inputs while a multiply is in progress.

## Interface
- N, 5: matrix dimension (rows = cols = N).
- W, 8: element width, two's complement.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; accepted only in IDLE.
- matA  in  N*N*W  operand A, packed.
- matB  in  N*N*W  operand B, packed.
- matC  out  N*N*W  result C, packed; reset 0.
- write  out  1  one-cycle strobe to the result bank; reset 0.
- busy  out  1  high in CALC and WRITE; reset 0.
- done  out  1  high from the WRITE cycle until the next accepted start; reset 0.
- ovf  out  1  sticky: some element exceeded the W-bit signed range during the current operation; cleared on accepted start; reset 0.

Packing rule: element (r,c) occupies bits [W*(N*r+c)+W-1 : W*(N*r+c)]. Row r is byte group r, matching the bank's row/column address split.

## Operation
- States: IDLE, CALC, WRITE.
- IDLE: when start=1, latch matA/matB into internal operand registers, set idx=0, clear ovf and done, and go to CALC. matC holds its previous value until it is overwritten element by element.
- CALC: r = idx/N, c = idx%N.
  - acc = Σk A[r][k]·B[k][c], computed with signed products (2W bits) and a 2W+3 = 19-bit accumulator.
  - The result byte for (r,c) is written into matC.
  - If acc is outside [-128,127], set ovf.
  - idx increments; after idx = N*N-1, go to WRITE.
- WRITE: write=1 for exactly one cycle, done=1, then go to IDLE.
- start while busy: ignored, with no effect on state, idx, or operands.
- start in the same cycle the FSM returns to IDLE from WRITE: not possible; the next start is sampled in IDLE.
- Reset asserted mid-operation: asynchronously returns to IDLE. All outputs, idx, and operand registers go to 0, and no write strobe is issued.

## Timing
- Accepted start edge = cycle 0.
- Elements 0..24 are written on edges 1..25, with matC[idx] updated at edge idx+1.
- write is high during cycle 26 (after edge 26). matC is final and stable at that point and stays stable until the next accepted start.
- busy is high from edge 1 through the end of cycle 26.
- Throughput: one multiply per 27 cycles (the start must be re-sampled in IDLE).
- No combinational path from start to any output.

## Configuration
- MAT_MUL_SAT_EN defined: an out-of-range acc saturates to 127 or -128.
- MAT_MUL_SAT_EN undefined: the result is acc[W-1:0] (wrap).
- ovf behaves identically in both builds.

## Structure
- Package mat_pkg:
  - constants N, W, ACC_W = 2*W+3;
  - state enum {IDLE, CALC, WRITE};
  - index-to-bit-offset function W*(N*r+c).
- Sub-module mat_dot5 (combinational):
  - inputs: N operands from row r and N operands from column c;
  - outputs: the ACC_W-bit sum, the W-bit result (saturated or wrapped per macro), and an out-of-range flag.
- Top module holds the FSM, idx counter, operand latches, and matC register.

## Test plan
- A = identity, B = arbitrary ramp (element i = i) → matC equals B; write is a single pulse in cycle 26; busy covers cycles 1–26.
- Only A[1][2]=3 and B[2][4]=4 nonzero → matC bits [79:72] = 12, all other bytes 0, ovf=0.
- All elements 127 → acc = 80645. With SAT_EN: every byte 0x7F, ovf=1. Without: every byte 0x05, ovf=1.
- All elements -128 → acc = 81920. With SAT_EN: every byte 0x7F. Without: every byte 0x00. ovf=1 in both builds.
- start pulsed at cycle 5 with different operands → ignored; result matches the first operands and write count = 1.
- rst asserted at cycle 10 → matC = 0, busy = done = write = ovf = 0 immediately. A subsequent identity×ramp run completes correctly.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and packing helper for the 5x5 signed matrix multiplier.
package mat_pkg;
  localparam int N     = 5;
  localparam int W     = 8;
  localparam int ACC_W = 2 * W + 3;
  localparam int IDX_W = 5;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N * N - 1);
  localparam logic [2:0]       RC_LAST  = 3'(N - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2 ** (W - 1) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (W - 1)));
  localparam logic [W-1:0]            RES_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]            RES_MIN = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
  } dbg_t;

  // Bit offset of element (r,c) inside a packed N*N*W matrix.
  function automatic int bit_off(input int r, input int c);
    return W * (N * r + c);
  endfunction
endpackage

// File: rtl/mat_dot5.sv
// Combinational N-term signed dot product; MAT_MUL_SAT_EN selects saturation instead of wrap.
module mat_dot5
  import mat_pkg::*;
(
  input  logic [N*W-1:0]          i_row,
  input  logic [N*W-1:0]          i_col,
  output logic signed [ACC_W-1:0] o_acc,
  output logic [W-1:0]            o_res,
  output logic                    o_ovf
);
  logic signed [W-1:0]     w_a    [N];
  logic signed [W-1:0]     w_b    [N];
  logic signed [2*W-1:0]   w_prod [N];
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_hi;
  logic                    w_lo;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_a[k]    = i_row[k*W +: W];
      w_b[k]    = i_col[k*W +: W];
      w_prod[k] = w_a[k] * w_b[k];
      w_sum     = w_sum + {{(ACC_W - 2 * W){w_prod[k][2*W-1]}}, w_prod[k]};
    end
  end

  assign w_hi  = (w_sum > ACC_MAX);
  assign w_lo  = (w_sum < ACC_MIN);
  assign o_acc = w_sum;
  assign o_ovf = w_hi | w_lo;

`ifdef MAT_MUL_SAT_EN
  assign o_res = w_hi ? RES_MAX : (w_lo ? RES_MIN : w_sum[W-1:0]);
`else
  assign o_res = w_sum[W-1:0];
`endif
endmodule

// File: rtl/mat_mul_seq.sv
// Sequential 5x5 signed matrix multiplier, one result element per clock, then a write strobe.
// Optional build macro MAT_MUL_SAT_EN (saturating results, handled in mat_dot5).
module mat_mul_seq
  import mat_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N*W-1:0] matA,
  input  logic [N*N*W-1:0] matB,
  output logic [N*N*W-1:0] matC,
  output logic             write,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output dbg_t             o_dbg
);
  // Handshake: start is a level request sampled only in IDLE; write is a
  // one-cycle strobe with matC already final, and matC holds until the next start.
  state_t                  r_state;
  state_t                  w_next;
  logic [N*N*W-1:0]        r_a;
  logic [N*N*W-1:0]        r_b;
  logic [N*N*W-1:0]        r_mat_c;
  logic [IDX_W-1:0]        r_idx;
  logic [2:0]              r_row;
  logic [2:0]              r_col;
  logic                    r_write;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ovf;
  logic                    w_accept;
  logic [N*W-1:0]          w_row;
  logic [N*W-1:0]          w_col;
  logic signed [ACC_W-1:0] w_acc;
  logic [W-1:0]            w_res;
  logic                    w_ovf;

  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int k = 0; k < N; k++) begin
      w_row[k*W +: W] = r_a[bit_off(int'(r_row), k) +: W];
      w_col[k*W +: W] = r_b[bit_off(k, int'(r_col)) +: W];
    end
  end

  mat_dot5 u_dot (
    .i_row (w_row),
    .i_col (w_col),
    .o_acc (w_acc),
    .o_res (w_res),
    .o_ovf (w_ovf)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_idx == IDX_LAST) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are registered copies of the state, so they lag it by one
  // cycle and never see start combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mat_c <= '0;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (r_state != IDLE);
      r_write <= (r_state == WRITE);
      if (w_accept) begin
        r_a    <= matA;
        r_b    <= matB;
        r_idx  <= '0;
        r_row  <= '0;
        r_col  <= '0;
        r_ovf  <= 1'b0;
        r_done <= 1'b0;
      end else if (r_state == CALC) begin
        r_mat_c[bit_off(int'(r_row), int'(r_col)) +: W] <= w_res;
        if (w_ovf) r_ovf <= 1'b1;
        r_idx <= r_idx + 5'd1;
        if (r_col == RC_LAST) begin
          r_col <= '0;
          r_row <= r_row + 3'd1;
        end else begin
          r_col <= r_col + 3'd1;
        end
      end else if (r_state == WRITE) begin
        r_done <= 1'b1;
      end
    end
  end

  assign matC        = r_mat_c;
  assign write       = r_write;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ovf         = r_ovf;
  assign o_dbg.state = r_state;
  assign o_dbg.idx   = r_idx;
  assign o_dbg.acc   = w_acc;
endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed and random checks of mat_mul_seq against an integer matrix-product model.
module tb_mat_mul_seq;
  import mat_pkg::*;

  localparam int MW = N * N * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [MW-1:0] matA;
  logic [MW-1:0] matB;
  logic [MW-1:0] matC;
  logic          write;
  logic          busy;
  logic          done;
  logic          ovf;
  dbg_t          dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] exp_q[$];
  logic          exp_ovf_q[$];

  mat_mul_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .matA  (matA),
    .matB  (matB),
    .matC  (matC),
    .write (write),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .o_dbg (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the unpacked elements.
  function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                output logic [MW-1:0] res, output logic ov);
    int s;
    logic [W-1:0] byte_v;
    res = '0;
    ov  = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(a[W*(N*r+k) +: W])) * int'($signed(b[W*(N*k+c) +: W]));
        if (s > 127 || s < -128) ov = 1'b1;
`ifdef MAT_MUL_SAT_EN
        if (s > 127)       byte_v = 8'h7F;
        else if (s < -128) byte_v = 8'h80;
        else               byte_v = s[7:0];
`else
        byte_v = s[7:0];
`endif
        res[W*(N*r+c) +: W] = byte_v;
      end
    end
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < N * N; i++) m[W*i +: W] = W'($urandom_range(0, 255));
    return m;
  endfunction

  // Driver: one multiply with per-cycle timing checks; optional ignored start
  // at cycle 5 and optional reset abort at a given cycle.
  task automatic run_mult(input string name, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input bit inject, input int abort_cyc);
    int            writes;
    logic [MW-1:0] e_c;
    logic          e_ovf;
    logic [MW-1:0] last_c;
    logic          dummy_o;
    logic [MW-1:0] dummy_c;
    writes = 0;
    last_c = '0;
    @(negedge clk);
    matA  = a;
    matB  = b;
    start = 1'b1;
    model(a, b, e_c, e_ovf);
    exp_q.push_back(e_c);
    exp_ovf_q.push_back(e_ovf);
    @(posedge clk);
    #1;
    start = 1'b0;
    matA  = rand_mat();
    matB  = rand_mat();
    for (int cyc = 1; cyc <= 28; cyc++) begin
      if (inject && cyc == 5) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (abort_cyc == cyc) begin
        rst = 1'b1;
        #1;
        check({name, " abort matC"}, matC, '0);
        check({name, " abort busy"}, MW'(busy), '0);
        check({name, " abort done"}, MW'(done), '0);
        check({name, " abort write"}, MW'(write), '0);
        check({name, " abort ovf"}, MW'(ovf), '0);
        check({name, " abort state"}, MW'(dbg.state), MW'(IDLE));
        dummy_c = exp_q.pop_front();
        dummy_o = exp_ovf_q.pop_front();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({name, " post-abort write"}, MW'(write), '0);
        return;
      end
      check($sformatf("%s busy c%0d", name, cyc), MW'(busy), MW'(cyc <= 26));
      check($sformatf("%s write c%0d", name, cyc), MW'(write), MW'(cyc == 26));
      if (write) begin
        writes++;
        if (exp_q.size() == 0) begin
          check({name, " unexpected write"}, MW'(1), MW'(0));
        end else begin
          last_c = exp_q.pop_front();
          check({name, " matC"}, matC, last_c);
          check({name, " ovf"}, MW'(ovf), MW'(exp_ovf_q.pop_front()));
          check({name, " done"}, MW'(done), MW'(1));
        end
      end
      if (cyc == 28) begin
        check({name, " matC stable"}, matC, last_c);
        check({name, " done held"}, MW'(done), MW'(1));
      end
    end
    check({name, " write count"}, MW'(writes), MW'(1));
  endtask

  logic [MW-1:0] ident;
  logic [MW-1:0] ramp;
  logic [MW-1:0] sa;
  logic [MW-1:0] sb;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    matA  = '0;
    matB  = '0;
    ident = '0;
    ramp  = '0;
    for (int i = 0; i < N; i++) ident[W*(N*i+i) +: W] = 8'd1;
    for (int i = 0; i < N * N; i++) ramp[W*i +: W] = W'(i);

    repeat (3) @(posedge clk);
    #1;
    check("reset matC", matC, '0);
    check("reset write", MW'(write), '0);
    check("reset busy", MW'(busy), '0);
    check("reset done", MW'(done), '0);
    check("reset ovf", MW'(ovf), '0);
    check("reset state", MW'(dbg.state), MW'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    run_mult("ident_ramp", ident, ramp, 1'b0, 0);
    check("ident_ramp equals B", matC, ramp);

    sa = '0;
    sb = '0;
    sa[W*(N*1+2) +: W] = 8'd3;
    sb[W*(N*2+4) +: W] = 8'd4;
    run_mult("sparse", sa, sb, 1'b0, 0);
    check("sparse byte 9", MW'(matC[79:72]), MW'(12));
    check("sparse others", matC & ~(MW'(8'hFF) << 72), '0);
    check("sparse ovf", MW'(ovf), '0);

    run_mult("all127", {(N*N){8'h7F}}, {(N*N){8'h7F}}, 1'b0, 0);
`ifdef MAT_MUL_SAT_EN
    check("all127 byte0", MW'(matC[7:0]), MW'(8'h7F));
`else
    check("all127 byte0", MW'(matC[7:0]), MW'(8'h05));
`endif
    check("all127 ovf", MW'(ovf), MW'(1));

    run_mult("allm128", {(N*N){8'h80}}, {(N*N){8'h80}}, 1'b0, 0);
`ifdef MAT_MUL_SAT_EN
    check("allm128 byte24", MW'(matC[199:192]), MW'(8'h7F));
`else
    check("allm128 byte24", MW'(matC[199:192]), MW'(8'h00));
`endif
    check("allm128 ovf", MW'(ovf), MW'(1));

    run_mult("ignored_start", ramp, ident, 1'b1, 0);
    check("ignored_start result", matC, ramp);

    run_mult("abort", ident, ramp, 1'b0, 10);
    check("abort queue empty", MW'(exp_q.size()), '0);
    run_mult("after_abort", ident, ramp, 1'b0, 0);
    check("after_abort equals B", matC, ramp);

    for (int t = 0; t < 3; t++) run_mult($sformatf("rand%0d", t), rand_mat(), rand_mat(), 1'b0, 0);

    check("final queue empty", MW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
